// File: rtl/reg_file_arbiter.sv
// Round-robin arbiter sharing one single-port register file between NREQ requesters.
// Each granted request is sequenced IDLE -> ISSUE (-> RESP for reads) -> IDLE.
module reg_file_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 3,
    parameter int DW   = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   REQ,
    input  logic [NREQ-1:0]   REQ_WR,
    input  logic [NREQ*AW-1:0] REQ_ADDR,
    input  logic [NREQ*DW-1:0] REQ_DATA,
    output logic [NREQ-1:0]   GNT,
    output logic [NREQ-1:0]   RVALID,
    output logic [DW-1:0]     RDATA,
    output logic              BUSY,
    output logic              RF_WEN,
    output logic              RF_OEN,
    output logic [AW-1:0]     RF_ADDR,
    output logic [DW-1:0]     RF_DIN,
    input  logic [DW-1:0]     RF_DOUT
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win_q;
    logic          wr_q;

    logic          any;
    logic [PW-1:0] win;
    logic [PW-1:0] ptr_nxt;
    logic [PW:0]   sum;

    // Descending scan so the requester nearest above ptr is the last to assign.
    always_comb begin
        any = 1'b0;
        win = ptr;
        sum = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (PW + 1)'(k);
            if (sum >= (PW + 1)'(NREQ)) begin
                sum = sum - (PW + 1)'(NREQ);
            end
            if (REQ[sum[PW-1:0]]) begin
                any = 1'b1;
                win = sum[PW-1:0];
            end
        end
        ptr_nxt = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
    end

    assign BUSY = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            ptr     <= '0;
            win_q   <= '0;
            wr_q    <= 1'b0;
            GNT     <= '0;
            RVALID  <= '0;
            RDATA   <= '0;
            RF_WEN  <= 1'b0;
            RF_OEN  <= 1'b0;
            RF_ADDR <= '0;
            RF_DIN  <= '0;
        end else begin
            GNT    <= '0;
            RVALID <= '0;
            RF_WEN <= 1'b0;
            RF_OEN <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any) begin
                        win_q   <= win;
                        wr_q    <= REQ_WR[win];
                        ptr     <= ptr_nxt;
                        GNT     <= NREQ'(1) << win;
                        RF_WEN  <= REQ_WR[win];
                        RF_OEN  <= ~REQ_WR[win];
                        RF_ADDR <= REQ_ADDR[int'(win)*AW +: AW];
                        RF_DIN  <= REQ_DATA[int'(win)*DW +: DW];
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= wr_q ? IDLE : RESP;
                end
                RESP: begin
                    RDATA  <= RF_DOUT;
                    RVALID <= NREQ'(1) << win_q;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Directed bench for reg_file_arbiter with a behavioural register file
// and a queue of expected read responses.
module tb_reg_file_arbiter;

    logic        CLK;
    logic        RST;
    logic [1:0]  REQ;
    logic [1:0]  REQ_WR;
    logic [5:0]  REQ_ADDR;
    logic [15:0] REQ_DATA;
    logic [1:0]  GNT;
    logic [1:0]  RVALID;
    logic [7:0]  RDATA;
    logic        BUSY;
    logic        RF_WEN;
    logic        RF_OEN;
    logic [2:0]  RF_ADDR;
    logic [7:0]  RF_DIN;
    logic [7:0]  RF_DOUT;

    typedef struct packed {
        logic [1:0] rv;
        logic [7:0] d;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    logic [7:0] rf[8];
    logic [7:0] shadow[8];
    int         nchk = 0;
    int         npass = 0;

    reg_file_arbiter #(.NREQ(2), .AW(3), .DW(8)) dut (
        .CLK(CLK),
        .RST(RST),
        .REQ(REQ),
        .REQ_WR(REQ_WR),
        .REQ_ADDR(REQ_ADDR),
        .REQ_DATA(REQ_DATA),
        .GNT(GNT),
        .RVALID(RVALID),
        .RDATA(RDATA),
        .BUSY(BUSY),
        .RF_WEN(RF_WEN),
        .RF_OEN(RF_OEN),
        .RF_ADDR(RF_ADDR),
        .RF_DIN(RF_DIN),
        .RF_DOUT(RF_DOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 8'h00;
        RF_DOUT = 8'h00;
    end

    always @(posedge CLK) begin
        if (RF_WEN) rf[RF_ADDR] <= RF_DIN;
        if (RF_OEN) RF_DOUT <= rf[RF_ADDR];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        assert (got === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            check("wen_oen_excl", 32'(RF_WEN & RF_OEN), 0);
            check("gnt_onehot", 32'($onehot0(GNT)), 1);
            if (RVALID != 2'b00) begin
                if (q.size() == 0) begin
                    check("rvalid_unexpected", 32'(RVALID), 0);
                end else begin
                    e = q.pop_front();
                    check("rvalid", 32'(RVALID), 32'(e.rv));
                    check("rdata", 32'(RDATA), 32'(e.d));
                end
            end
        end
    end

    task automatic wait_resp(input string tag);
        for (int i = 0; i < 8 && q.size() != 0; i++) @(posedge CLK);
        check(tag, q.size(), 0);
    endtask

    task automatic access(input int r, input logic wr, input logic [2:0] a,
                          input logic [7:0] d);
        logic got;
        @(negedge CLK);
        REQ[r] = 1'b1;
        REQ_WR[r] = wr;
        REQ_ADDR[r*3 +: 3] = a;
        REQ_DATA[r*8 +: 8] = d;
        if (wr) shadow[a] = d;
        else q.push_back('{rv: 2'(1 << r), d: shadow[a]});
        got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(posedge CLK);
            #1;
            got = GNT[r];
        end
        check("gnt_seen", 32'(got), 1);
        @(posedge CLK);
        #1;
        REQ[r] = 1'b0;
        if (!wr) wait_resp("read_resp");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_g;
        int         gcnt;
        RST = 1'b1;
        REQ = '0;
        REQ_WR = '0;
        REQ_ADDR = '0;
        REQ_DATA = '0;
        for (int i = 0; i < 8; i++) shadow[i] = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_gnt", 32'(GNT), 0);
        check("rst_rvalid", 32'(RVALID), 0);
        check("rst_wen_oen", 32'({RF_WEN, RF_OEN}), 0);
        check("rst_rdata", 32'(RDATA), 0);
        check("rst_addr_din", 32'({RF_ADDR, RF_DIN}), 0);
        check("rst_busy", 32'(BUSY), 0);
        @(negedge CLK);
        RST = 1'b0;

        // Test 1: single write
        @(negedge CLK);
        REQ[0] = 1'b1; REQ_WR[0] = 1'b1;
        REQ_ADDR[2:0] = 3'd5; REQ_DATA[7:0] = 8'hA5;
        shadow[5] = 8'hA5;
        @(posedge CLK); #1;
        check("t1_gnt", 32'(GNT), 32'h1);
        check("t1_wen_oen", 32'({RF_WEN, RF_OEN}), 32'h2);
        check("t1_addr", 32'(RF_ADDR), 5);
        check("t1_din", 32'(RF_DIN), 32'hA5);
        check("t1_busy", 32'(BUSY), 1);
        @(posedge CLK); #1;
        REQ[0] = 1'b0;
        check("t1_busy_fall", 32'(BUSY), 0);
        check("t1_gnt_pulse", 32'(GNT), 0);
        check("t1_wen_off", 32'(RF_WEN), 0);

        // Test 2: read back through requester 1
        @(negedge CLK);
        REQ[1] = 1'b1; REQ_WR[1] = 1'b0; REQ_ADDR[5:3] = 3'd5;
        q.push_back('{rv: 2'b10, d: 8'hA5});
        @(posedge CLK); #1;
        check("t2_gnt", 32'(GNT), 32'h2);
        check("t2_wen_oen", 32'({RF_WEN, RF_OEN}), 32'h1);
        check("t2_addr", 32'(RF_ADDR), 5);
        @(posedge CLK); #1;
        REQ[1] = 1'b0;
        check("t2_resp_busy", 32'(BUSY), 1);
        check("t2_resp_oen", 32'(RF_OEN), 0);
        @(posedge CLK); #1;
        check("t2_rvalid", 32'(RVALID), 32'h2);
        check("t2_rdata", 32'(RDATA), 32'hA5);
        @(posedge CLK); #1;
        check("t2_rvalid_pulse", 32'(RVALID), 0);
        check("t2_rdata_hold", 32'(RDATA), 32'hA5);
        check("t2_idle", 32'(BUSY), 0);

        // Test 3: both requesters hold REQ, grants must alternate
        @(negedge CLK);
        REQ = 2'b11; REQ_WR = 2'b11;
        REQ_ADDR = {3'd2, 3'd1}; REQ_DATA = {8'h22, 8'h11};
        shadow[1] = 8'h11; shadow[2] = 8'h22;
        exp_g = 2'b01;
        gcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); #1;
            if (GNT != 2'b00) begin
                check("t3_gnt", 32'(GNT), 32'(exp_g));
                exp_g = {exp_g[0], exp_g[1]};
                gcnt++;
            end
        end
        REQ = 2'b00;
        check("t3_gnt_count", gcnt, 4);

        // Test 4: random writes to every address, then reads in reverse
        for (int a = 0; a < 8; a++) begin
            access(a % 2, 1'b1, 3'(a), 8'($urandom));
        end
        for (int a = 7; a >= 0; a--) begin
            access(a % 2, 1'b0, 3'(a), 8'h00);
        end

        // Test 5: reset during RESP abandons the read and clears the pointer
        @(negedge CLK);
        REQ[0] = 1'b1; REQ_WR[0] = 1'b0; REQ_ADDR[2:0] = 3'd3;
        q.push_back('{rv: 2'b01, d: shadow[3]});
        @(posedge CLK); #1;
        check("t5_gnt", 32'(GNT), 32'h1);
        @(posedge CLK); #1;
        REQ[0] = 1'b0;
        check("t5_resp_busy", 32'(BUSY), 1);
        @(negedge CLK);
        RST = 1'b1;
        q.delete();
        @(posedge CLK); #1;
        check("t5_rst_rvalid", 32'(RVALID), 0);
        check("t5_rst_busy", 32'(BUSY), 0);
        check("t5_rst_rdata", 32'(RDATA), 0);
        check("t5_rst_bus", 32'({RF_WEN, RF_OEN, RF_ADDR, RF_DIN}), 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) begin
            @(posedge CLK); #1;
            check("t5_no_rvalid", 32'({GNT, RVALID}), 0);
        end
        @(negedge CLK);
        REQ = 2'b11; REQ_WR = 2'b11;
        REQ_ADDR = {3'd4, 3'd0}; REQ_DATA = {8'hC3, 8'h5A};
        shadow[0] = 8'h5A; shadow[4] = 8'hC3;
        @(posedge CLK); #1;
        check("t5_first_gnt", 32'(GNT), 32'h1);
        @(posedge CLK); #1;
        REQ[0] = 1'b0;
        @(posedge CLK); #1;
        check("t5_second_gnt", 32'(GNT), 32'h2);
        @(posedge CLK); #1;
        REQ[1] = 1'b0;

        // Test 6: lone req1 with ptr at 0 wins at the first edge
        @(negedge CLK);
        REQ[1] = 1'b1; REQ_WR[1] = 1'b0; REQ_ADDR[5:3] = 3'd6;
        q.push_back('{rv: 2'b10, d: shadow[6]});
        @(posedge CLK); #1;
        check("t6_gnt", 32'(GNT), 32'h2);
        @(posedge CLK); #1;
        REQ[1] = 1'b0;
        wait_resp("t6_resp");

        // Confirm written data via a final read of address 0
        access(0, 1'b0, 3'd0, 8'h00);

        repeat (2) @(posedge CLK);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
